// File: rtl/mdu_seq_ctrl.sv
// Multiply/divide sequencer owning HI/LO: MUL busy MUL_CYCLES cycles, DIV 33 cycles, DIV by zero 1 cycle.
// A start while busy is not accepted; stall holds EXE until busy drops, and done pulses on the commit cycle.
module mdu_seq_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_ITERS  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  input  logic        rd_hi,
  input  logic        rd_lo,
  input  logic        flush,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);
  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DIV_FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] a_reg, b_reg, rem_reg;
  logic        mul_signed, qneg, rneg;
  logic        accept, sa, sb;
  logic [31:0] rs_mag, rt_mag;
  logic [63:0] a_ext, b_ext, product;
  logic [32:0] rem_sh, diff;
  logic        qbit;
  logic [31:0] rem_nxt;

  assign accept  = (state == S_IDLE) && start && !flush;
  assign busy    = (state != S_IDLE);
  assign stall   = busy & (start | rd_hi | rd_lo);
  assign mdu_out = rd_hi ? hi : lo;

  // Only DIV (op[0]==0) takes magnitudes; DIVU keeps the raw operands.
  assign sa     = (op == OP_DIV) & rs_value[31];
  assign sb     = (op == OP_DIV) & rt_value[31];
  assign rs_mag = sa ? -rs_value : rs_value;
  assign rt_mag = sb ? -rt_value : rt_value;

  assign a_ext   = {{32{mul_signed & a_reg[31]}}, a_reg};
  assign b_ext   = {{32{mul_signed & b_reg[31]}}, b_reg};
  assign product = a_ext * b_ext;

  // Remainder stays below the divisor, so the 33-bit difference sign is the borrow.
  assign rem_sh  = {rem_reg, a_reg[31]};
  assign diff    = rem_sh - {1'b0, b_reg};
  assign qbit    = ~diff[32];
  assign rem_nxt = qbit ? diff[31:0] : rem_sh[31:0];

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: state_nxt = S_MUL;
            OP_DIV, OP_DIVU:   state_nxt = (rt_value == 32'd0) ? S_DIV_FIX : S_DIV;
            default:           state_nxt = S_IDLE;
          endcase
        end
      end
      S_MUL: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (cnt == 5'd0) begin
          state_nxt = S_IDLE;
          done      = 1'b1;
        end
      end
      S_DIV: begin
        if (flush)             state_nxt = S_IDLE;
        else if (cnt == 5'd0)  state_nxt = S_DIV_FIX;
      end
      S_DIV_FIX: begin
        state_nxt = S_IDLE;
        done      = !flush;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi         <= 32'd0;
      lo         <= 32'd0;
      cnt        <= 5'd0;
      a_reg      <= 32'd0;
      b_reg      <= 32'd0;
      rem_reg    <= 32'd0;
      mul_signed <= 1'b0;
      qneg       <= 1'b0;
      rneg       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                a_reg      <= rs_value;
                b_reg      <= rt_value;
                mul_signed <= (op == OP_MULT);
                cnt        <= 5'(MUL_CYCLES - 1);
              end
              OP_DIV, OP_DIVU: begin
                if (rt_value == 32'd0) begin
                  // Divide by zero: preload the final result and skip the sign fix.
                  a_reg   <= 32'hFFFF_FFFF;
                  rem_reg <= rs_value;
                  qneg    <= 1'b0;
                  rneg    <= 1'b0;
                end else begin
                  a_reg   <= rs_mag;
                  b_reg   <= rt_mag;
                  rem_reg <= 32'd0;
                  qneg    <= sa ^ sb;
                  rneg    <= sa;
                  cnt     <= 5'(DIV_ITERS - 1);
                end
              end
              OP_MTHI: hi <= rs_value;
              OP_MTLO: lo <= rs_value;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
          if (done) {hi, lo} <= product;
        end
        S_DIV: begin
          a_reg   <= {a_reg[30:0], qbit};
          rem_reg <= rem_nxt;
          if (cnt != 5'd0) cnt <= cnt - 5'd1;
        end
        S_DIV_FIX: begin
          if (done) begin
            lo <= qneg ? -a_reg : a_reg;
            hi <= rneg ? -rem_reg : rem_reg;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Bench for mdu_seq_ctrl: countdown/arithmetic reference model checked every cycle, plus literal expectations.
module tb_mdu_seq_ctrl;
  localparam int MUL_CYCLES = 4;
  localparam int DIV_BUSY   = 33;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_value = 32'd0;
  logic [31:0] rt_value = 32'd0;
  logic        rd_hi = 1'b0;
  logic        rd_lo = 1'b0;
  logic        flush = 1'b0;
  logic        busy, stall, done;
  logic [31:0] hi, lo, mdu_out;

  int checks = 0;
  int errors = 0;

  mdu_seq_ctrl #(.MUL_CYCLES(MUL_CYCLES), .DIV_ITERS(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_value(rs_value),
    .rt_value(rt_value), .rd_hi(rd_hi), .rd_lo(rd_lo), .flush(flush),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo), .mdu_out(mdu_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remaining busy cycles plus a pending result computed with plain arithmetic.
  int          m_left = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_phi = 32'd0, m_plo = 32'd0;
  int          sa, sb;
  longint      sp;
  logic [63:0] up;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
    end else if (m_left > 0) begin
      if (flush) m_left = 0;
      else begin
        if (m_left == 1) begin
          m_hi = m_phi;
          m_lo = m_plo;
        end
        m_left--;
      end
    end else if (start && !flush) begin
      sa = rs_value;
      sb = rt_value;
      case (op)
        3'd0: begin sp = longint'(sa) * longint'(sb); {m_phi, m_plo} = sp; m_left = MUL_CYCLES; end
        3'd1: begin up = 64'(rs_value) * 64'(rt_value); {m_phi, m_plo} = up; m_left = MUL_CYCLES; end
        3'd2, 3'd3: begin
          if (rt_value == 32'd0) begin
            m_plo = 32'hFFFF_FFFF; m_phi = rs_value; m_left = 1;
          end else if (op == 3'd2 && rs_value == 32'h8000_0000 && rt_value == 32'hFFFF_FFFF) begin
            m_plo = 32'h8000_0000; m_phi = 32'd0; m_left = DIV_BUSY;
          end else if (op == 3'd2) begin
            m_plo = sa / sb; m_phi = sa % sb; m_left = DIV_BUSY;
          end else begin
            m_plo = rs_value / rt_value; m_phi = rs_value % rt_value; m_left = DIV_BUSY;
          end
        end
        3'd4: m_hi = rs_value;
        3'd5: m_lo = rs_value;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    check("busy", {31'd0, busy}, {31'd0, m_left != 0});
    check("stall", {31'd0, stall}, {31'd0, (m_left != 0) && (start || rd_hi || rd_lo)});
    check("done", {31'd0, done}, {31'd0, (m_left == 1) && !flush});
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("mdu_out", mdu_out, rd_hi ? m_hi : m_lo);
  end

  task automatic wait_idle(output int nbusy, output int nstall);
    nbusy = 0;
    nstall = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
      nbusy++;
      if (stall) nstall++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic op_run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic hold_lo, output int nbusy, output int nstall);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs_value = a; rt_value = b; rd_lo = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; rd_lo = hold_lo;
    wait_idle(nbusy, nstall);
  endtask

  int nb, ns;

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_hi", hi, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    op_run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, nb, ns);
    check("multu_busy_cycles", nb, MUL_CYCLES);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    op_run(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1, nb, ns);
    check("mult_stall_cycles", ns, 4);
    check("mult_mflo", mdu_out, 32'hFFFF_FFEB);
    check("mult_hi", hi, 32'hFFFF_FFFF);

    op_run(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, nb, ns);
    check("div_busy_cycles", nb, 33);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);

    op_run(3'd3, 32'd100, 32'd7, 1'b0, nb, ns);
    check("divu_lo", lo, 32'h0000_000E);
    check("divu_hi", hi, 32'h0000_0002);

    op_run(3'd2, 32'd5, 32'd0, 1'b0, nb, ns);
    check("div0_busy_cycles", nb, 1);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'h0000_0005);

    op_run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb, ns);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'h0000_0000);

    op_run(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, nb, ns);
    check("div_pos_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_pos_neg_hi", hi, 32'h0000_0001);

    op_run(3'd4, 32'h11, 32'd0, 1'b0, nb, ns);
    op_run(3'd5, 32'h22, 32'd0, 1'b0, nb, ns);
    check("mtlo_busy_cycles", nb, 0);

    // Flush at DIVU iteration 10.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd3; rs_value = 32'd100; rt_value = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_div_busy", {31'd0, busy}, 32'd0);
    check("flush_div_hi", hi, 32'h11);
    check("flush_div_lo", lo, 32'h22);

    // Flush together with start: not accepted.
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 3'd1; rs_value = 32'd3; rt_value = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", {31'd0, busy}, 32'd0);

    // Flush on the committing MUL cycle: no write.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd1; rs_value = 32'd5; rt_value = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_commit_lo", lo, 32'h22);
    check("flush_commit_busy", {31'd0, busy}, 32'd0);

    // Out-of-range op is ignored.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd6; rs_value = 32'h99;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("badop_busy", {31'd0, busy}, 32'd0);

    // Back-to-back: DIVU held by stall is accepted the cycle after done.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd1; rs_value = 32'd9; rt_value = 32'd9;
    @(posedge clk); #1;
    op = 3'd3; rs_value = 32'd100; rt_value = 32'd7;
    wait_idle(nb, ns);
    check("b2b_stall_cycles", ns, MUL_CYCLES);
    check("b2b_mul_lo", lo, 32'd81);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("b2b_div_busy", {31'd0, busy}, 32'd1);
    wait_idle(nb, ns);
    check("b2b_div_lo", lo, 32'h0000_000E);

    // MTHI then immediate MFHI.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd4; rs_value = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; rd_hi = 1'b1;
    @(negedge clk);
    check("mfhi_stall", {31'd0, stall}, 32'd0);
    check("mfhi_value", mdu_out, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    rd_hi = 1'b0;

    // Async reset in the middle of a MUL.
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; rs_value = 32'd11; rt_value = 32'd13;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_seq_ctrl.md
Name: mdu_seq_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the EXE stage of the 54-instruction pipelined CPU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EXE and owns the architectural HI/LO registers.
- Runs an iterative restoring divider and a latency-counted multiplier.
- Raises a stall to freeze IF/ID/EXE while a HI/LO consumer or a new MDU op meets a busy unit; its read port feeds the MDU_out leg of the writeback data mux.

Parameters:
- MUL_CYCLES, 4, busy cycles for MULT/MULTU (legal range 1..15).
- DIV_ITERS, 32, restoring-divide iterations (one quotient bit per cycle). Must equal the data width; fixed at 32.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  EXE holds a valid MDU op this cycle.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others treated as no-op.
- rs_value  in  32  operand A: dividend or multiplicand, or MTHI/MTLO source.
- rt_value  in  32  operand B: divisor or multiplier.
- rd_hi  in  1  MFHI in EXE.
- rd_lo  in  1  MFLO in EXE.
- flush  in  1  squash in-flight op (exception/redirect).
- busy  out  1  unit is sequencing (state != IDLE).
- stall  out  1  pipeline hold request.
- done  out  1  one-cycle pulse on the cycle HI/LO are committed by MUL or DIV.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.
- mdu_out  out  32  rd_hi ? hi : lo (combinational from registers).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, hi=0, lo=0, counter=0, busy=0, stall=0, done=0. Reset mid-operation aborts at once; no partial HI/LO write.
- States: IDLE, MUL, DIV, DIV_FIX.
- stall = busy & (start | rd_hi | rd_lo). Combinational, no other term.
- Acceptance: an op is accepted only when state=IDLE, start=1 and flush=0. Operands are latched at the accepting edge. A start while busy is not accepted; stall holds the instruction in EXE until busy drops.
- MTHI/MTLO: the accepting edge writes hi or lo from rs_value. State stays IDLE, busy stays 0, done is not pulsed.
- MULT/MULTU:
  - 64-bit product is computed from the latched operands (signed or unsigned); counter is loaded with MUL_CYCLES-1.
  - State MUL decrements the counter; on counter=0, {hi,lo}<=product, done=1, state goes to IDLE.
  - Busy for exactly MUL_CYCLES cycles.
- DIV/DIVU:
  - Latch magnitudes: for DIV, abs of each operand; for DIVU, the raw operands.
  - Record qneg = sa^sb and rneg = sa (DIV only).
  - DIV performs DIV_ITERS restoring steps: remainder shifted left with the next dividend bit, trial subtract, quotient bit = no-borrow.
  - DIV_FIX applies the signs: lo = qneg ? -q : q, hi = rneg ? -r : r. It then pulses done and goes to IDLE.
  - Busy for DIV_ITERS+1 = 33 cycles.
- Divide by zero (rt_value=0): skip DIV and enter DIV_FIX directly with lo=32'hFFFFFFFF and hi=rs_value, no sign fix. Busy for 1 cycle.
- 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0. This is the natural result of magnitude arithmetic.
- flush:
  - While busy: state goes to IDLE on the next edge, HI/LO unchanged, no done.
  - In the same cycle as start: flush wins and the op is not accepted.
  - In the same cycle as the committing edge (last MUL cycle or DIV_FIX): flush wins and there is no write.
- Back-to-back ops: busy=0 in the cycle after done, so a stalled start is accepted in that cycle. An MFHI/MFLO held by stall reads the new value in that same cycle.
- Out-of-range op values with start=1: ignored, no state change.

Test Plan:
- Reset then MULTU 0xFFFFFFFF x 0xFFFFFFFF: busy for 4 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done for 1 cycle.
- MULT -3 x 7 followed by MFLO held in EXE: stall=1 for 4 cycles; next cycle mdu_out=0xFFFFFFEB; hi=0xFFFFFFFF.
- DIV -7 / 2: 33 busy cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7: lo=0x0000000E, hi=0x00000002.
- DIV 5 / 0: busy for 1 cycle, then lo=0xFFFFFFFF, hi=0x00000005.
- DIVU 100 / 7 with flush at iteration 10, prior hi=0x11, lo=0x22: state goes to IDLE next edge, hi/lo unchanged, no done.
- MTHI 0xDEADBEEF then immediate MFHI: no stall, mdu_out=0xDEADBEEF next cycle. Async rst_n low during MUL: hi=lo=0, busy=0 without a clock edge.
